// File: rtl/snn_input_packet_buffer_if.sv
// Host/grid side signal bundle for snn_input_packet_buffer.
// The tick statistics signals exist only when SNN_IBUF_TICK_STATS_EN is defined.
interface snn_input_packet_buffer_if #(
    parameter int PACKET_WIDTH = 30,
    parameter int DEPTH        = 512
);
    localparam int PTR_W = $clog2(DEPTH) + 1;

    logic                    wr_en;
    logic [PACKET_WIDTH-1:0] wr_data;
    logic                    commit;
    logic                    flush;
    logic                    full;
    logic                    ren_to_input_buffer;
    logic [PACKET_WIDTH-1:0] packet_in;
    logic                    input_buffer_empty;
    logic [PTR_W-1:0]        pending_count;
    logic                    overflow_err;
    logic                    underflow_err;
`ifdef SNN_IBUF_TICK_STATS_EN
    logic                    tick;
    logic [15:0]             last_tick_pkt_count;
`endif

`ifdef SNN_IBUF_TICK_STATS_EN
    modport master (
        output wr_en, wr_data, commit, flush, ren_to_input_buffer, tick,
        input  full, packet_in, input_buffer_empty, pending_count,
               overflow_err, underflow_err, last_tick_pkt_count
    );
    modport slave (
        input  wr_en, wr_data, commit, flush, ren_to_input_buffer, tick,
        output full, packet_in, input_buffer_empty, pending_count,
               overflow_err, underflow_err, last_tick_pkt_count
    );
`else
    modport master (
        output wr_en, wr_data, commit, flush, ren_to_input_buffer,
        input  full, packet_in, input_buffer_empty, pending_count,
               overflow_err, underflow_err
    );
    modport slave (
        input  wr_en, wr_data, commit, flush, ren_to_input_buffer,
        output full, packet_in, input_buffer_empty, pending_count,
               overflow_err, underflow_err
    );
`endif
endinterface

// File: rtl/snn_input_packet_buffer.sv
// Frame-committed input packet FIFO feeding the grid's packet input.
// Host writes are invisible to the reader until committed; the grid pops
// committed packets with a registered read.
// Optional macro SNN_IBUF_TICK_STATS_EN adds a per-tick pop counter.
module snn_input_packet_buffer #(
    parameter int PACKET_WIDTH = 30,
    parameter int DEPTH        = 512
) (
    input logic                      clk,
    input logic                      reset,
    snn_input_packet_buffer_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH) + 1;
    localparam int AW    = PTR_W - 1;

    logic [PTR_W-1:0]        r_wr_ptr;
    logic [PTR_W-1:0]        r_commit_ptr;
    logic [PTR_W-1:0]        r_rd_ptr;
    logic [PACKET_WIDTH-1:0] r_mem [DEPTH];
    logic [PACKET_WIDTH-1:0] r_packet;
    logic                    r_overflow;
    logic                    r_underflow;

    logic                    w_full;
    logic                    w_empty;
    logic                    w_do_write;
    logic                    w_do_pop;
    logic [PTR_W-1:0]        w_wr_ptr_nxt;

    // Status flags and accepted-operation strobes from current pointers.
    always_comb begin
        w_full       = (r_wr_ptr - r_rd_ptr) == PTR_W'(DEPTH);
        w_empty      = (r_rd_ptr == r_commit_ptr);
        w_do_write   = bus.wr_en && !w_full && !bus.flush;
        w_do_pop     = bus.ren_to_input_buffer && !w_empty && !bus.flush;
        w_wr_ptr_nxt = r_wr_ptr + PTR_W'(w_do_write);
    end

    // Pointer update; commit publishes the pointer including this cycle's write.
    always_ff @(posedge clk) begin
        if (reset || bus.flush) begin
            r_wr_ptr     <= '0;
            r_commit_ptr <= '0;
            r_rd_ptr     <= '0;
        end else begin
            r_wr_ptr <= w_wr_ptr_nxt;
            if (bus.commit) begin
                r_commit_ptr <= w_wr_ptr_nxt;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
        end
    end

    // Storage write port.
    always_ff @(posedge clk) begin
        if (w_do_write) begin
            r_mem[r_wr_ptr[AW-1:0]] <= bus.wr_data;
        end
    end

    // Registered read port; holds its value when no pop is accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_packet <= '0;
        end else if (w_do_pop) begin
            r_packet <= r_mem[r_rd_ptr[AW-1:0]];
        end
    end

    // Sticky error flags, cleared only by reset; flush suppresses the strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (!bus.flush) begin
            if (bus.wr_en && w_full) begin
                r_overflow <= 1'b1;
            end
            if (bus.ren_to_input_buffer && w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign bus.full               = w_full;
    assign bus.input_buffer_empty = w_empty;
    assign bus.pending_count      = r_commit_ptr - r_rd_ptr;
    assign bus.packet_in          = r_packet;
    assign bus.overflow_err       = r_overflow;
    assign bus.underflow_err      = r_underflow;

`ifdef SNN_IBUF_TICK_STATS_EN
    logic [15:0] r_pop_cnt;
    logic [15:0] r_last_cnt;
    logic [15:0] w_pop_cnt_upd;

    // Saturating pop count including any pop in the current cycle.
    always_comb begin
        w_pop_cnt_upd = r_pop_cnt;
        if (w_do_pop && (r_pop_cnt != '1)) begin
            w_pop_cnt_upd = r_pop_cnt + 16'd1;
        end
    end

    // Tick latches the running count and restarts it; flush leaves it alone.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pop_cnt  <= '0;
            r_last_cnt <= '0;
        end else if (bus.tick) begin
            r_last_cnt <= w_pop_cnt_upd;
            r_pop_cnt  <= '0;
        end else begin
            r_pop_cnt  <= w_pop_cnt_upd;
        end
    end

    assign bus.last_tick_pkt_count = r_last_cnt;
`endif
endmodule

// File: tb/tb_snn_input_packet_buffer.sv
// Self-checking bench for snn_input_packet_buffer with a queue-based model.
module tb_snn_input_packet_buffer;
    localparam int PW    = 30;
    localparam int DEPTH = 512;
    localparam int PTR_W = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    snn_input_packet_buffer_if #(.PACKET_WIDTH(PW), .DEPTH(DEPTH)) bus ();

    snn_input_packet_buffer #(.PACKET_WIDTH(PW), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model: queue of stored packets, the first m_pub of which are published.
    logic [PW-1:0] m_q[$];
    int            m_pub;
    logic [PW-1:0] m_pkt;
    bit            m_ovf, m_udf;
    int            m_cnt, m_last;

    task automatic idle_inputs();
        bus.wr_en = 1'b0; bus.wr_data = '0; bus.commit = 1'b0;
        bus.ren_to_input_buffer = 1'b0; bus.flush = 1'b0;
`ifdef SNN_IBUF_TICK_STATS_EN
        bus.tick = 1'b0;
`endif
    endtask

    task automatic cycle(input bit we, input logic [PW-1:0] d, input bit cm,
                         input bit rn, input bit fl, input bit tk);
        bit popped;
        bit was_full;
        int inc;
        bus.wr_en = we; bus.wr_data = d; bus.commit = cm;
        bus.ren_to_input_buffer = rn; bus.flush = fl;
`ifdef SNN_IBUF_TICK_STATS_EN
        bus.tick = tk;
`endif
        @(posedge clk);
        popped   = 1'b0;
        was_full = (m_q.size() == DEPTH);
        if (fl) begin
            m_q.delete();
            m_pub = 0;
        end else begin
            if (rn) begin
                if (m_pub > 0) begin
                    m_pkt = m_q.pop_front();
                    m_pub--;
                    popped = 1'b1;
                end else begin
                    m_udf = 1'b1;
                end
            end
            if (we) begin
                if (!was_full) m_q.push_back(d);
                else m_ovf = 1'b1;
            end
            if (cm) m_pub = m_q.size();
        end
        inc = popped ? ((m_cnt == 65535) ? 65535 : m_cnt + 1) : m_cnt;
        if (tk) begin
            m_last = inc;
            m_cnt  = 0;
        end else begin
            m_cnt = inc;
        end
        #1;
        idle_inputs();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.wr_en = 1'($urandom); bus.wr_data = PW'($urandom);
        bus.commit = 1'($urandom); bus.ren_to_input_buffer = 1'($urandom);
        @(posedge clk);
        m_q.delete(); m_pub = 0; m_pkt = '0;
        m_ovf = 1'b0; m_udf = 1'b0; m_cnt = 0; m_last = 0;
        #1;
        reset = 1'b0;
        idle_inputs();
    endtask

    task automatic test_reset();
        logic [PW+PTR_W+3:0] exp_v;
        do_reset();
        exp_v = {{PW{1'b0}}, 1'b1, 1'b0, {PTR_W{1'b0}}, 1'b0, 1'b0};
        n_checks++;
        if ({bus.packet_in, bus.input_buffer_empty, bus.full, bus.pending_count,
             bus.overflow_err, bus.underflow_err} !== exp_v) begin
            n_fail++;
            $display("FAIL reset_state: got pkt=%h empty=%b full=%b pend=%0d ovf=%b udf=%b expected %h",
                     bus.packet_in, bus.input_buffer_empty, bus.full, bus.pending_count,
                     bus.overflow_err, bus.underflow_err, exp_v);
        end
    endtask

    task automatic test_uncommitted();
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            cycle(1, PW'(i), 0, 0, 0, 0);
            n_checks++;
            if (bus.input_buffer_empty !== 1'b1 || bus.pending_count !== '0) begin
                n_fail++;
                $display("FAIL uncommitted_hidden: got empty=%b pend=%0d expected empty=1 pend=0",
                         bus.input_buffer_empty, bus.pending_count);
            end
        end
        cycle(0, '0, 0, 1, 0, 0);
        n_checks++;
        if (bus.underflow_err !== 1'b1 || bus.packet_in !== '0) begin
            n_fail++;
            $display("FAIL underflow_on_empty: got udf=%b pkt=%h expected udf=1 pkt=0",
                     bus.underflow_err, bus.packet_in);
        end
    endtask

    task automatic test_commit_read();
        logic [PW-1:0] exp_d[3];
        exp_d = '{PW'('h0A), PW'('h0B), PW'('h0C)};
        do_reset();
        cycle(1, exp_d[0], 0, 0, 0, 0);
        cycle(1, exp_d[1], 0, 0, 0, 0);
        cycle(1, exp_d[2], 1, 0, 0, 0);
        n_checks++;
        if (bus.pending_count !== PTR_W'(3) || bus.input_buffer_empty !== 1'b0) begin
            n_fail++;
            $display("FAIL commit_same_cycle: got pend=%0d empty=%b expected pend=3 empty=0",
                     bus.pending_count, bus.input_buffer_empty);
        end
        for (int i = 0; i < 3; i++) begin
            cycle(0, '0, 0, 1, 0, 0);
            n_checks++;
            if (bus.packet_in !== exp_d[i] || bus.packet_in !== m_pkt) begin
                n_fail++;
                $display("FAIL b2b_pop%0d: got %h expected %h", i, bus.packet_in, exp_d[i]);
            end
        end
        n_checks++;
        if (bus.input_buffer_empty !== 1'b1 || bus.underflow_err !== 1'b0) begin
            n_fail++;
            $display("FAIL empty_after_drain: got empty=%b udf=%b expected empty=1 udf=0",
                     bus.input_buffer_empty, bus.underflow_err);
        end
    endtask

    task automatic test_fill_wrap();
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < DEPTH; i++) cycle(1, PW'($urandom), 0, 0, 0, 0);
            n_checks++;
            if (bus.full !== 1'b1 || bus.pending_count !== '0) begin
                n_fail++;
                $display("FAIL fill_full r%0d: got full=%b pend=%0d expected full=1 pend=0",
                         r, bus.full, bus.pending_count);
            end
            cycle(1, PW'($urandom), 0, 0, 0, 0);
            n_checks++;
            if (bus.overflow_err !== 1'b1 || bus.full !== 1'b1) begin
                n_fail++;
                $display("FAIL overflow r%0d: got ovf=%b full=%b expected ovf=1 full=1",
                         r, bus.overflow_err, bus.full);
            end
            cycle(0, '0, 1, 0, 0, 0);
            n_checks++;
            if (bus.pending_count !== PTR_W'(DEPTH)) begin
                n_fail++;
                $display("FAIL commit_full r%0d: got pend=%0d expected %0d", r, bus.pending_count, DEPTH);
            end
            for (int i = 0; i < DEPTH; i++) begin
                cycle(0, '0, 0, 1, 0, 0);
                n_checks++;
                if (bus.packet_in !== m_pkt) begin
                    n_fail++;
                    $display("FAIL wrap_order r%0d i%0d: got %h expected %h", r, i, bus.packet_in, m_pkt);
                end
            end
            n_checks++;
            if (bus.input_buffer_empty !== 1'b1 || bus.full !== 1'b0 || bus.underflow_err !== 1'b0) begin
                n_fail++;
                $display("FAIL wrap_drained r%0d: got empty=%b full=%b udf=%b expected 1 0 0",
                         r, bus.input_buffer_empty, bus.full, bus.underflow_err);
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        cycle(1, PW'($urandom), 1, 0, 0, 0);
        for (int i = 0; i < 1000; i++) begin
            cycle(1, PW'($urandom), 1, 1, 0, 0);
            n_checks++;
            if (bus.packet_in !== m_pkt || bus.pending_count > PTR_W'(1) ||
                bus.overflow_err !== 1'b0 || bus.underflow_err !== 1'b0) begin
                n_fail++;
                $display("FAIL stream c%0d: got pkt=%h pend=%0d ovf=%b udf=%b expected pkt=%h pend<=1 no errors",
                         i, bus.packet_in, bus.pending_count, bus.overflow_err, bus.underflow_err, m_pkt);
            end
        end
        cycle(0, '0, 0, 1, 0, 0);
        n_checks++;
        if (bus.packet_in !== m_pkt || bus.input_buffer_empty !== 1'b1) begin
            n_fail++;
            $display("FAIL stream_tail: got pkt=%h empty=%b expected pkt=%h empty=1",
                     bus.packet_in, bus.input_buffer_empty, m_pkt);
        end
    endtask

    task automatic test_flush();
        logic [PW-1:0] held;
        logic [PW-1:0] fresh;
        do_reset();
        cycle(1, PW'('h155), 1, 0, 0, 0);
        cycle(0, '0, 0, 1, 0, 0);
        held = bus.packet_in;
        for (int i = 0; i < 5; i++) cycle(1, PW'($urandom), (i == 4), 0, 0, 0);
        for (int i = 0; i < 2; i++) cycle(1, PW'($urandom), 0, 0, 0, 0);
        cycle(1, PW'($urandom), 1, 1, 1, 0);
        n_checks++;
        if (bus.pending_count !== '0 || bus.input_buffer_empty !== 1'b1 ||
            bus.packet_in !== PW'('h155) || bus.packet_in !== held || bus.underflow_err !== 1'b0) begin
            n_fail++;
            $display("FAIL flush: got pend=%0d empty=%b pkt=%h udf=%b expected pend=0 empty=1 pkt=155 udf=0",
                     bus.pending_count, bus.input_buffer_empty, bus.packet_in, bus.underflow_err);
        end
        fresh = PW'($urandom);
        cycle(1, fresh, 1, 0, 0, 0);
        n_checks++;
        if (bus.pending_count !== PTR_W'(1)) begin
            n_fail++;
            $display("FAIL post_flush_commit: got pend=%0d expected 1", bus.pending_count);
        end
        cycle(0, '0, 0, 1, 0, 0);
        n_checks++;
        if (bus.packet_in !== fresh || bus.input_buffer_empty !== 1'b1) begin
            n_fail++;
            $display("FAIL post_flush_read: got pkt=%h empty=%b expected pkt=%h empty=1",
                     bus.packet_in, bus.input_buffer_empty, fresh);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(99) < 70), PW'($urandom), ($urandom_range(99) < 20),
                  ($urandom_range(99) < 50), ($urandom_range(99) < 2), ($urandom_range(99) < 5));
            n_checks++;
            if (bus.packet_in !== m_pkt || bus.input_buffer_empty !== (m_pub == 0) ||
                bus.pending_count !== PTR_W'(m_pub) || bus.full !== (m_q.size() == DEPTH) ||
                bus.overflow_err !== m_ovf || bus.underflow_err !== m_udf) begin
                n_fail++;
                $display("FAIL random c%0d: got pkt=%h empty=%b pend=%0d full=%b ovf=%b udf=%b expected pkt=%h pend=%0d stored=%0d ovf=%b udf=%b",
                         i, bus.packet_in, bus.input_buffer_empty, bus.pending_count, bus.full,
                         bus.overflow_err, bus.underflow_err, m_pkt, m_pub, m_q.size(), m_ovf, m_udf);
            end
`ifdef SNN_IBUF_TICK_STATS_EN
            n_checks++;
            if (bus.last_tick_pkt_count !== 16'(m_last)) begin
                n_fail++;
                $display("FAIL random_tick c%0d: got %0d expected %0d", i, bus.last_tick_pkt_count, m_last);
            end
`endif
        end
    endtask

`ifdef SNN_IBUF_TICK_STATS_EN
    task automatic test_tick_stats();
        do_reset();
        for (int i = 0; i < 7; i++) cycle(1, PW'($urandom), (i == 6), 0, 0, 0);
        for (int i = 0; i < 7; i++) cycle(0, '0, 0, 1, 0, (i == 6));
        n_checks++;
        if (bus.last_tick_pkt_count !== 16'd7) begin
            n_fail++;
            $display("FAIL tick_seven: got %0d expected 7", bus.last_tick_pkt_count);
        end
        cycle(0, '0, 0, 0, 0, 1);
        n_checks++;
        if (bus.last_tick_pkt_count !== 16'd0) begin
            n_fail++;
            $display("FAIL tick_zero: got %0d expected 0", bus.last_tick_pkt_count);
        end
        for (int i = 0; i < 3; i++) cycle(1, PW'($urandom), (i == 2), 0, 0, 0);
        cycle(0, '0, 0, 1, 0, 0);
        cycle(0, '0, 0, 1, 0, 0);
        cycle(0, '0, 0, 0, 1, 0);
        cycle(0, '0, 0, 0, 0, 1);
        n_checks++;
        if (bus.last_tick_pkt_count !== 16'd2) begin
            n_fail++;
            $display("FAIL tick_flush_keeps: got %0d expected 2", bus.last_tick_pkt_count);
        end
    endtask
`endif

    initial begin
        reset = 1'b0;
        idle_inputs();
        m_pub = 0; m_pkt = '0; m_ovf = 1'b0; m_udf = 1'b0; m_cnt = 0; m_last = 0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_uncommitted();
        test_commit_read();
        test_fill_wrap();
        test_back_to_back();
        test_flush();
        test_random();
`ifdef SNN_IBUF_TICK_STATS_EN
        test_tick_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/snn_input_packet_buffer.md
Name: snn_input_packet_buffer

Overview:
- Frame-committed packet FIFO that drives the input-packet interface of RANCNetworkGrid_1x1 (`packet_in`, `input_buffer_empty`, `ren_to_input_buffer`).
- The host or DMA side writes the 30-bit spike packets for one tick or picture, then asserts `commit`.
- Only committed packets become visible to the grid, which pops them with `ren_to_input_buffer`.
- Replaces the bench-side packet feeder in SoC integration.

Parameters:
- PACKET_WIDTH, 30, width of one input packet.
- DEPTH, 512, FIFO entries; must be a power of two and at least 2.
- PTR_W, $clog2(DEPTH)+1, pointer width including the wrap bit (derived, not overridden).

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- wr_en  input  1  host write strobe.
- wr_data  input  PACKET_WIDTH  host packet.
- commit  input  1  publish all packets written so far to the reader.
- flush  input  1  discard all contents, committed and uncommitted.
- full  output  1  FIFO holds DEPTH entries.
- ren_to_input_buffer  input  1  pop request from the grid.
- packet_in  output  PACKET_WIDTH  popped packet, registered.
- input_buffer_empty  output  1  no committed packet available.
- pending_count  output  PTR_W  committed, unread entries.
- overflow_err  output  1  sticky: write attempted while full.
- underflow_err  output  1  sticky: pop attempted while empty.

Behaviour:
- Reset values:
  - Internal pointers `wr_ptr`, `commit_ptr`, `rd_ptr` = 0.
  - `packet_in` = 0, `input_buffer_empty` = 1, `full` = 0, `pending_count` = 0, `overflow_err` = 0, `underflow_err` = 0.
- Reset mid-operation discards all contents. It takes effect on the same edge regardless of other inputs.
- Pointers are PTR_W wide. The low bits index storage, the MSB is the wrap bit, and all arithmetic is modulo 2^PTR_W.
- `full` = (`wr_ptr` - `rd_ptr`) == DEPTH. Combinational from registers.
- `input_buffer_empty` = (`rd_ptr` == `commit_ptr`). `pending_count` = `commit_ptr` - `rd_ptr`. Both combinational from registers.
- Write:
  - `wr_en` and not `full` → mem[`wr_ptr`] <= `wr_data`, `wr_ptr`++.
  - `wr_en` and `full` → packet dropped, `overflow_err` <= 1.
- Commit: `commit_ptr` <= the `wr_ptr` value after this cycle's write. A packet written in the commit cycle is therefore published.
- Commit latency: `input_buffer_empty` deasserts on the cycle after the commit edge.
- Read:
  - `ren_to_input_buffer` and not `input_buffer_empty` → `packet_in` <= mem[`rd_ptr`], `rd_ptr`++. Data is valid one cycle after `ren`.
  - `ren` while empty → `packet_in` holds, `rd_ptr` unchanged, `underflow_err` <= 1.
- Simultaneous write and read are both performed. Read never returns an uncommitted slot, so there is no read/write hazard on the same entry.
- Uncommitted writes stay invisible indefinitely. Further commits extend the published region.
- The grid may pop back-to-back every cycle. The last committed packet is popped on the cycle `empty` is 0 and `pending_count` is 1; `empty` rises on the next cycle.
- `flush` (reset excepted, highest priority):
  - All pointers <= 0; `packet_in` holds.
  - `wr_en`, `commit` and `ren` in the same cycle are ignored.
  - Sticky errors are cleared only by `reset`.
- Storage: single-write, single-read RAM with a registered read. Depth DEPTH × PACKET_WIDTH.

Optional Feature:
- Macro: `SNN_IBUF_TICK_STATS_EN`.
- When defined, the block adds:
  - Input `tick` (1 bit).
  - Output `last_tick_pkt_count` (16 bits, reset 0).
  - An internal 16-bit saturating counter of successful pops.
- Counter behaviour:
  - On `tick`, `last_tick_pkt_count` <= the counter value including any pop in the same cycle, and the counter <= 0.
  - The counter saturates at 0xFFFF.
  - `flush` does not clear it.
- When not defined, the port, the output and the counter are absent. The remaining behaviour is identical.

Test Plan:
- Reset, write 3 packets 0x1, 0x2, 0x3 with no commit → `input_buffer_empty` stays 1, `pending_count` 0; `ren` → `underflow_err` = 1, `packet_in` stays 0.
- Write 0x0A, 0x0B, then `commit` in the same cycle as the write of 0x0C → `pending_count` = 3 next cycle. Three back-to-back `ren` give `packet_in` 0x0A, 0x0B, 0x0C on the cycles after each `ren`; `empty` = 1 after the third pop.
- Fill DEPTH = 512 entries → `full` = 1. A 513th write sets `overflow_err`. Commit and pop all 512 → data order intact across wrap. Repeat to exercise pointer MSB wrap.
- Continuous write plus commit every cycle while the grid pops every cycle for 1000 cycles → no loss, no errors, `pending_count` ≤ 1.
- Write 5, commit, write 2, assert `flush` together with `ren` → `pending_count` 0, `empty` 1, `packet_in` unchanged. Subsequent write/commit/read works from address 0.
- Macro `SNN_IBUF_TICK_STATS_EN` defined: commit 7 packets, pop 7, pulse `tick` → `last_tick_pkt_count` = 7. A pop coinciding with `tick` is counted in the latched value.
